// File: rtl/nibbler_run_ctrl.sv
// Run/halt/single-step sequencer for the Nibbler core: owns the fetch/execute
// phase bit, the core clock-enable, the PC breakpoint and the retire counter.
module nibbler_run_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             halt,
    input  logic             step,
    input  logic             bp_en,
    input  logic [11:0]      bp_addr,
    input  logic [11:0]      PC,
    output logic             cpu_en,
    output logic             PHASE,
    output logic [1:0]       status,
    output logic             break_hit,
    output logic [CNT_W-1:0] instr_cnt
);

    // run/halt/step are single-cycle command pulses sampled on the rising edge;
    // there is no ready/ack, a pulse that the current state ignores is dropped.
    typedef enum logic [1:0] {
        S_HALT  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    state_t state, state_nxt;
    logic   bp_skip, halt_pend;
    logic   bp_match, retire, enter_go, enter_stop;

    always_comb begin
        bp_match   = bp_en && !PHASE && (PC == bp_addr) && !bp_skip;
        cpu_en     = ((state == S_RUN) || (state == S_STEP)) && !bp_match;
        retire     = cpu_en && PHASE;
        state_nxt  = state;
        enter_go   = 1'b0;
        enter_stop = 1'b0;

        case (state)
            S_HALT, S_BREAK: begin
                if (halt)      state_nxt = S_HALT;
                else if (step) state_nxt = S_STEP;
                else if (run)  state_nxt = S_RUN;
            end
            S_RUN: begin
                if (bp_match)                          state_nxt = S_BREAK;
                else if (retire && (halt_pend || halt)) state_nxt = S_HALT;
            end
            S_STEP: begin
                if (bp_match)    state_nxt = S_BREAK;
                else if (retire) state_nxt = S_HALT;
            end
            default: state_nxt = S_HALT;
        endcase

        if (state_nxt != state) begin
            enter_go   = (state_nxt == S_RUN) || (state_nxt == S_STEP);
            enter_stop = (state_nxt == S_HALT) || (state_nxt == S_BREAK);
        end
    end

    assign status    = state;
    assign break_hit = (state == S_BREAK);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_HALT;
            PHASE     <= 1'b0;
            instr_cnt <= '0;
            bp_skip   <= 1'b0;
            halt_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (cpu_en) PHASE <= !PHASE;
            if (retire) instr_cnt <= instr_cnt + CNT_W'(1);

            // Skip lets a resume step over the very address that stopped us.
            if (enter_go)                bp_skip <= 1'b1;
            else if (cpu_en && !PHASE)   bp_skip <= 1'b0;

            if (enter_stop)                  halt_pend <= 1'b0;
            else if (state == S_RUN && halt) halt_pend <= 1'b1;
        end
    end

endmodule
